axis_route_demux: RTL and testbench

- Egress-side decoder for the 8-bit routing tag (tdest) carried on vFPGA AXI4SR streams leaving the data switch.
- Accepts one tagged stream, decodes tdest on the first beat of each packet, and steers the whole packet to one of N_DEST output streams.
- Packets with an undecodable tag are drained and dropped, with a sticky error flag and per-port statistics.
- Sits between the switch egress and the per-region user-logic or DTU consumers.

---
 rtl/axis_route_demux.sv | 165 ++++++++++++++++
 tb/tb_axis_route_demux.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_route_demux.sv
// Routing-tag decoder: steers each AXI4SR packet to one of N_DEST outputs by its head tdest.
// Define AXIS_ROUTE_DEMUX_STATS_EN to build the pkt_cnt/drop_cnt statistics counters.
module axis_route_demux #(
  parameter int N_DEST    = 2,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 6
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_BITS-1:0]   s_tdata,
  input  logic [DATA_BITS/8-1:0] s_tkeep,
  input  logic                   s_tlast,
  input  logic [ID_BITS-1:0]     s_tid,
  input  logic [7:0]             s_tdest,
  output logic [N_DEST-1:0]      m_tvalid,
  input  logic [N_DEST-1:0]      m_tready,
  output logic [DATA_BITS-1:0]   m_tdata,
  output logic [DATA_BITS/8-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic [ID_BITS-1:0]     m_tid,
  output logic                   decode_err,
  input  logic                   err_clr,
  output logic [N_DEST*32-1:0]   pkt_cnt,
  output logic [15:0]            drop_cnt
);

  localparam int SEL_W = (N_DEST > 1) ? $clog2(N_DEST) : 1;
  localparam logic [4:0] N_DEST_L = 5'(N_DEST);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t state, state_n;

  logic                   slot_valid;
  logic [SEL_W-1:0]       slot_sel;
  logic [DATA_BITS-1:0]   slot_data;
  logic [DATA_BITS/8-1:0] slot_keep;
  logic                   slot_last;
  logic [ID_BITS-1:0]     slot_id;

  logic             ready_en;
  logic             slot_free;
  logic             accept;
  logic             tag_ok;
  logic             load;
  logic             drop_set;
  logic [SEL_W-1:0] dest_sel;

  assign dest_sel  = s_tdest[SEL_W-1:0];
  assign tag_ok    = (s_tdest[7:4] == 4'd0) && ({1'b0, s_tdest[3:0]} < N_DEST_L);
  assign slot_free = !slot_valid || m_tready[slot_sel];
  // ready_en keeps s_tready low while reset is held and until the first clock after it
  assign s_tready  = ready_en && ((state == DROP) || slot_free);
  assign accept    = s_tvalid && s_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_n;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    drop_set = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (tag_ok) begin
            load = 1'b1;
            if (!s_tlast) state_n = FWD;
          end else begin
            drop_set = 1'b1;
            if (!s_tlast) state_n = DROP;
          end
        end
      end
      FWD: begin
        if (accept) begin
          load = 1'b1;
          if (s_tlast) state_n = IDLE;
        end
      end
      DROP: begin
        if (accept && s_tlast) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Only a head beat latches a new destination; body beats reuse the packet's sel
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      slot_valid <= 1'b0;
      slot_sel   <= '0;
      slot_data  <= '0;
      slot_keep  <= '0;
      slot_last  <= 1'b0;
      slot_id    <= '0;
    end else if (load) begin
      slot_valid <= 1'b1;
      slot_data  <= s_tdata;
      slot_keep  <= s_tkeep;
      slot_last  <= s_tlast;
      slot_id    <= s_tid;
      if (state == IDLE) slot_sel <= dest_sel;
    end else if (slot_free) begin
      slot_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)        decode_err <= 1'b0;
    else if (drop_set) decode_err <= 1'b1;
    else if (err_clr)  decode_err <= 1'b0;
  end

  always_comb begin
    m_tvalid = '0;
    for (int i = 0; i < N_DEST; i++) m_tvalid[i] = slot_valid && (slot_sel == SEL_W'(i));
  end

  assign m_tdata = slot_data;
  assign m_tkeep = slot_keep;
  assign m_tlast = slot_last;
  assign m_tid   = slot_id;

`ifdef AXIS_ROUTE_DEMUX_STATS_EN
  logic [31:0]      pkt_cnt_r [N_DEST];
  logic [15:0]      drop_cnt_r;
  logic             pkt_done;
  logic [SEL_W-1:0] cnt_sel;

  // A forwarded packet completes when its tlast beat is loaded into the slot
  assign pkt_done = load && s_tlast;
  assign cnt_sel  = (state == IDLE) ? dest_sel : slot_sel;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_DEST; i++) pkt_cnt_r[i] <= '0;
      drop_cnt_r <= '0;
    end else begin
      if (pkt_done) pkt_cnt_r[cnt_sel] <= pkt_cnt_r[cnt_sel] + 32'd1;
      if (drop_set && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < N_DEST; i++) pkt_cnt[i*32 +: 32] = pkt_cnt_r[i];
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_route_demux.sv
// Self-checking bench for axis_route_demux: packet-level scoreboard fed from randomized packets.
module tb_axis_route_demux;

  localparam int N_DEST    = 2;
  localparam int DATA_BITS = 32;
  localparam int ID_BITS   = 6;
`ifdef AXIS_ROUTE_DEMUX_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [5:0]  id;
  } beat_t;

  logic                 aclk, areset;
  logic                 s_tvalid, s_tready, s_tlast;
  logic [31:0]          s_tdata;
  logic [3:0]           s_tkeep;
  logic [5:0]           s_tid;
  logic [7:0]           s_tdest;
  logic [N_DEST-1:0]    m_tvalid, m_tready;
  logic [31:0]          m_tdata;
  logic [3:0]           m_tkeep;
  logic                 m_tlast;
  logic [5:0]           m_tid;
  logic                 decode_err, err_clr;
  logic [N_DEST*32-1:0] pkt_cnt;
  logic [15:0]          drop_cnt;

  int    checks = 0;
  int    fails = 0;
  int    cyc = 0;
  bit    mon_en = 1'b1;
  bit    rnd_ready = 1'b0;
  int    hold_cnt = 0;
  int    valid_seen = 0;
  beat_t exp_q [N_DEST][$];
  int    cap_cyc[$];
  int    cap_port[$];
  int    exp_pkt [N_DEST];
  int    exp_drop;
  bit    exp_err;

  axis_route_demux #(.N_DEST(N_DEST), .DATA_BITS(DATA_BITS), .ID_BITS(ID_BITS)) dut (
    .aclk(aclk), .areset(areset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tid(m_tid),
    .decode_err(decode_err), .err_clr(err_clr), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Output readiness: all-ones, random, or port 0 held low for hold_cnt cycles
  initial begin
    m_tready = '1;
    forever begin
      @(posedge aclk);
      #2;
      if (hold_cnt > 0) begin
        m_tready    = '1;
        m_tready[0] = 1'b0;
        hold_cnt--;
      end else if (rnd_ready) begin
        m_tready = N_DEST'($urandom);
      end else begin
        m_tready = '1;
      end
    end
  end

  // Scoreboard: every transfer must match the head of its port's expected queue,
  // and a stalled output must hold valid and payload until it is taken
  initial begin
    beat_t got, held;
    logic [N_DEST-1:0] held_valid;
    bit hold_pend;
    hold_pend = 1'b0;
    held = '0;
    held_valid = '0;
    forever begin
      @(negedge aclk);
      got = {m_tdata, m_tkeep, m_tlast, m_tid};
      if (areset || !mon_en) begin
        hold_pend = 1'b0;
      end else begin
        if (m_tvalid != '0) valid_seen++;
        if (hold_pend) begin
          checks++;
          if (m_tvalid !== held_valid || got !== held) begin
            $display("[TB] FAIL stall_stable: valid=%b beat=%h, required valid=%b beat=%h",
                     m_tvalid, got, held_valid, held);
            fails++;
          end
        end
        hold_pend = 1'b0;
        for (int i = 0; i < N_DEST; i++) begin
          if (m_tvalid[i] && m_tready[i]) begin
            checks++;
            if (exp_q[i].size() == 0) begin
              $display("[TB] FAIL unexpected_beat port %0d: got %h, required no beat", i, got);
              fails++;
            end else begin
              if (got !== exp_q[i][0]) begin
                $display("[TB] FAIL beat port %0d: got %h, required %h", i, got, exp_q[i][0]);
                fails++;
              end
              void'(exp_q[i].pop_front());
            end
            cap_cyc.push_back(cyc + 1);
            cap_port.push_back(i);
          end else if (m_tvalid[i]) begin
            hold_pend  = 1'b1;
            held       = got;
            held_valid = m_tvalid;
          end
        end
      end
    end
  end

  task automatic reset_model();
    for (int i = 0; i < N_DEST; i++) begin
      exp_q[i].delete();
      exp_pkt[i] = 0;
    end
    exp_drop = 0;
    exp_err  = 1'b0;
    cap_cyc.delete();
    cap_port.delete();
  endtask

  // Offers one packet beat by beat; the model is updated from the head tag alone
  task automatic send_packet(input int len, input logic [7:0] head_dest,
                             input logic [7:0] rest_dest, input logic [5:0] id,
                             output int stalls, output int acc0);
    beat_t beats[16];
    int    d;
    bit    ok;
    d  = int'(head_dest & 8'h0F);
    ok = ((head_dest >> 4) == 0) && (d < N_DEST);
    stalls = 0;
    acc0 = 0;
    for (int b = 0; b < len; b++) begin
      beats[b].data = $urandom;
      beats[b].keep = 4'($urandom);
      beats[b].last = (b == len - 1);
      beats[b].id   = id;
    end
    if (ok) begin
      for (int b = 0; b < len; b++) exp_q[d].push_back(beats[b]);
      exp_pkt[d]++;
    end else begin
      if (exp_drop < 65535) exp_drop++;
      exp_err = 1'b1;
    end
    for (int b = 0; b < len; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = beats[b].data;
      s_tkeep  = beats[b].keep;
      s_tlast  = beats[b].last;
      s_tid    = id;
      s_tdest  = (b == 0) ? head_dest : rest_dest;
      for (int n = 0; ; n++) begin
        @(negedge aclk);
        if (s_tready) break;
        stalls++;
        if (n >= 200) begin
          checks++;
          fails++;
          $display("[TB] FAIL s_tready_timeout: waited %0d cycles, required accept", n);
          break;
        end
      end
      if (b == 0) acc0 = cyc + 1;
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int pending;
    for (int n = 0; n < limit; n++) begin
      pending = 0;
      for (int i = 0; i < N_DEST; i++) pending += exp_q[i].size();
      if (pending == 0) break;
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tid = '0; s_tdest = '0; err_clr = 1'b0;
    reset_model();
    repeat (2) @(posedge aclk);
    #1;
    checks += 6;
    if (s_tready !== 1'b0) begin $display("[TB] FAIL reset_s_tready: got %b, required 0", s_tready); fails++; end
    if (m_tvalid !== '0) begin $display("[TB] FAIL reset_m_tvalid: got %b, required 0", m_tvalid); fails++; end
    if ({m_tdata, m_tkeep, m_tlast, m_tid} !== '0) begin
      $display("[TB] FAIL reset_payload: got %h, required 0", {m_tdata, m_tkeep, m_tlast, m_tid}); fails++;
    end
    if (decode_err !== 1'b0) begin $display("[TB] FAIL reset_decode_err: got %b, required 0", decode_err); fails++; end
    if (pkt_cnt !== '0) begin $display("[TB] FAIL reset_pkt_cnt: got %h, required 0", pkt_cnt); fails++; end
    if (drop_cnt !== '0) begin $display("[TB] FAIL reset_drop_cnt: got %h, required 0", drop_cnt); fails++; end
    areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic test_basic_route();
    int st, acc0;
    cap_cyc.delete(); cap_port.delete();
    send_packet(4, 8'h01, 8'h01, 6'h11, st, acc0);
    wait_drain(100);
    checks++;
    if (cap_cyc.size() != 4) begin $display("[TB] FAIL basic_beats: got %0d, required 4", cap_cyc.size()); fails++; end
    for (int k = 0; k < cap_cyc.size() && k < 4; k++) begin
      checks++;
      if (cap_port[k] != 1 || cap_cyc[k] != acc0 + 1 + k) begin
        $display("[TB] FAIL basic_timing beat %0d: port %0d cycle %0d, required port 1 cycle %0d",
                 k, cap_port[k], cap_cyc[k], acc0 + 1 + k);
        fails++;
      end
    end
    checks++;
    if (pkt_cnt[63:32] !== (STATS_ON ? 32'(exp_pkt[1]) : 32'd0)) begin
      $display("[TB] FAIL basic_pkt_cnt1: got %0d, required %0d", pkt_cnt[63:32], STATS_ON ? exp_pkt[1] : 0); fails++;
    end
  endtask

  task automatic test_tdest_ignored();
    int st, acc0;
    cap_cyc.delete(); cap_port.delete();
    send_packet(3, 8'h00, 8'h01, 6'h05, st, acc0);
    wait_drain(100);
    checks++;
    if (cap_port.size() != 3 || cap_port.sum() != 0) begin
      $display("[TB] FAIL body_tdest: got %0d beats port-sum %0d, required 3 beats on port 0", cap_port.size(), cap_port.sum());
      fails++;
    end
    for (int i = 0; i < N_DEST; i++) begin
      checks++;
      if (pkt_cnt[i*32 +: 32] !== (STATS_ON ? 32'(exp_pkt[i]) : 32'd0)) begin
        $display("[TB] FAIL body_pkt_cnt%0d: got %0d, required %0d", i, pkt_cnt[i*32 +: 32], STATS_ON ? exp_pkt[i] : 0);
        fails++;
      end
    end
  endtask

  task automatic test_drop();
    int st1, st2, acc0, vs0;
    vs0 = valid_seen;
    send_packet(3, 8'h12, 8'h00, 6'h01, st1, acc0);
    send_packet(2, 8'h05, 8'h00, 6'h02, st2, acc0);
    repeat (2) @(posedge aclk);
    #1;
    checks += 4;
    if (st1 + st2 != 0) begin $display("[TB] FAIL drop_stalls: got %0d, required 0", st1 + st2); fails++; end
    if (valid_seen != vs0) begin $display("[TB] FAIL drop_valid: got %0d pulses, required 0", valid_seen - vs0); fails++; end
    if (decode_err !== exp_err) begin $display("[TB] FAIL drop_decode_err: got %b, required %b", decode_err, exp_err); fails++; end
    if (drop_cnt !== (STATS_ON ? 16'(exp_drop) : 16'd0)) begin
      $display("[TB] FAIL drop_cnt: got %0d, required %0d", drop_cnt, STATS_ON ? exp_drop : 0); fails++;
    end
    err_clr = 1'b1;
    @(posedge aclk);
    #1;
    err_clr = 1'b0;
    exp_err = 1'b0;
    checks++;
    if (decode_err !== exp_err) begin $display("[TB] FAIL err_clr: got %b, required %b", decode_err, exp_err); fails++; end
    // Clear held through a dropped head: the set must win
    err_clr = 1'b1;
    send_packet(1, 8'hF0, 8'h00, 6'h03, st1, acc0);
    err_clr = 1'b0;
    checks++;
    if (decode_err !== exp_err) begin $display("[TB] FAIL set_vs_clr: got %b, required %b", decode_err, exp_err); fails++; end
  endtask

  task automatic test_backpressure();
    int st, acc0, port0_beats;
    bit seen_low;
    cap_cyc.delete(); cap_port.delete();
    seen_low = 1'b0;
    fork
      send_packet(8, 8'h00, 8'h01, 6'h2A, st, acc0);
      begin
        repeat (3) @(posedge aclk);
        hold_cnt = 5;
        repeat (2) @(negedge aclk);
        seen_low = (s_tready === 1'b0);
      end
    join
    wait_drain(100);
    port0_beats = 0;
    foreach (cap_port[k]) if (cap_port[k] == 0) port0_beats++;
    checks += 3;
    if (!seen_low) begin $display("[TB] FAIL bp_s_tready: got 1 while slot full, required 0"); fails++; end
    if (st < 4) begin $display("[TB] FAIL bp_stalls: got %0d, required >= 4", st); fails++; end
    if (port0_beats != 8) begin $display("[TB] FAIL bp_beats: got %0d, required 8", port0_beats); fails++; end
  endtask

  task automatic test_back_to_back();
    int st, acc0, a;
    cap_cyc.delete(); cap_port.delete();
    send_packet(1, 8'h00, 8'h00, 6'h10, st, acc0);
    send_packet(1, 8'h01, 8'h00, 6'h11, st, a);
    send_packet(1, 8'h00, 8'h00, 6'h12, st, a);
    send_packet(1, 8'h01, 8'h00, 6'h13, st, a);
    wait_drain(100);
    checks++;
    if (cap_cyc.size() != 4) begin $display("[TB] FAIL b2b_beats: got %0d, required 4", cap_cyc.size()); fails++; end
    for (int k = 0; k < cap_cyc.size() && k < 4; k++) begin
      checks++;
      if (cap_port[k] != k % 2 || cap_cyc[k] != acc0 + 1 + k) begin
        $display("[TB] FAIL b2b_order beat %0d: port %0d cycle %0d, required port %0d cycle %0d",
                 k, cap_port[k], cap_cyc[k], k % 2, acc0 + 1 + k);
        fails++;
      end
    end
    for (int i = 0; i < N_DEST; i++) begin
      checks++;
      if (pkt_cnt[i*32 +: 32] !== (STATS_ON ? 32'(exp_pkt[i]) : 32'd0)) begin
        $display("[TB] FAIL b2b_pkt_cnt%0d: got %0d, required %0d", i, pkt_cnt[i*32 +: 32], STATS_ON ? exp_pkt[i] : 0);
        fails++;
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int st, acc0;
    mon_en = 1'b0;
    for (int b = 0; b < 3; b++) begin
      s_tvalid = 1'b1; s_tdata = $urandom; s_tkeep = 4'hF; s_tlast = 1'b0;
      s_tid = 6'h07; s_tdest = 8'h00;
      for (int n = 0; n < 200; n++) begin
        @(negedge aclk);
        if (s_tready) break;
      end
      @(posedge aclk);
      #1;
    end
    areset = 1'b1;
    s_tvalid = 1'b0;
    #1;
    checks += 4;
    if (m_tvalid !== '0) begin $display("[TB] FAIL mid_reset_valid: got %b, required 0", m_tvalid); fails++; end
    if (s_tready !== 1'b0) begin $display("[TB] FAIL mid_reset_s_tready: got %b, required 0", s_tready); fails++; end
    if ({m_tdata, m_tkeep, m_tlast, m_tid} !== '0) begin
      $display("[TB] FAIL mid_reset_payload: got %h, required 0", {m_tdata, m_tkeep, m_tlast, m_tid}); fails++;
    end
    if (pkt_cnt !== '0 || drop_cnt !== '0) begin
      $display("[TB] FAIL mid_reset_counters: got %h/%h, required 0", pkt_cnt, drop_cnt); fails++;
    end
    @(posedge aclk);
    #1;
    areset = 1'b0;
    reset_model();
    mon_en = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    send_packet(3, 8'h01, 8'h00, 6'h09, st, acc0);
    wait_drain(100);
    checks += 2;
    if (cap_port.size() != 3 || cap_port.sum() != 3) begin
      $display("[TB] FAIL post_reset_route: got %0d beats port-sum %0d, required 3 beats on port 1", cap_port.size(), cap_port.sum());
      fails++;
    end
    if (pkt_cnt !== (STATS_ON ? {32'd1, 32'd0} : 64'd0)) begin
      $display("[TB] FAIL post_reset_pkt_cnt: got %h, required %h", pkt_cnt, STATS_ON ? {32'd1, 32'd0} : 64'd0); fails++;
    end
  endtask

  task automatic test_random();
    int st, acc0, r, pending;
    logic [7:0] hd;
    rnd_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       hd = 8'(r % N_DEST);
      else if (r == 8) hd = 8'($urandom_range(N_DEST, 15));
      else             hd = {4'($urandom_range(1, 15)), 4'($urandom)};
      send_packet($urandom_range(1, 5), hd, 8'($urandom), 6'($urandom), st, acc0);
    end
    rnd_ready = 1'b0;
    wait_drain(400);
    pending = 0;
    for (int i = 0; i < N_DEST; i++) pending += exp_q[i].size();
    checks += 3;
    if (pending != 0) begin $display("[TB] FAIL rand_drain: got %0d beats pending, required 0", pending); fails++; end
    if (decode_err !== exp_err) begin $display("[TB] FAIL rand_decode_err: got %b, required %b", decode_err, exp_err); fails++; end
    if (drop_cnt !== (STATS_ON ? 16'(exp_drop) : 16'd0)) begin
      $display("[TB] FAIL rand_drop_cnt: got %0d, required %0d", drop_cnt, STATS_ON ? exp_drop : 0); fails++;
    end
    for (int i = 0; i < N_DEST; i++) begin
      checks++;
      if (pkt_cnt[i*32 +: 32] !== (STATS_ON ? 32'(exp_pkt[i]) : 32'd0)) begin
        $display("[TB] FAIL rand_pkt_cnt%0d: got %0d, required %0d", i, pkt_cnt[i*32 +: 32], STATS_ON ? exp_pkt[i] : 0);
        fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_tdest_ignored();
    test_drop();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
